serial_subtractor: RTL and testbench

Bit-serial, LSB-first two's-complement subtractor computing `diff = a - b - bin` over WIDTH clock cycles, with a single borrow flip-flop. It is the sequential, inverse-operation counterpart to the combinational full adder used in the datapath. It serves area-constrained paths in the Snell's-law fixed-point pipeline where a full-width parallel subtractor is not justified. Operands are loaded on a start pulse, and results are returned with a one-cycle done pulse.

---
 rtl/serial_subtractor.sv | 98 +++++++++
 tb/tb_serial_subtractor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first two's-complement subtractor: diff = a - b - bin over WIDTH cycles,
// using a single borrow flop; results are held until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    // state | meaning
    // IDLE  | waiting for start, results held
    // SHIFT | one operand bit pair consumed per cycle
    // DONE  | results valid, done pulse; start here is accepted back-to-back
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d;
    logic             br_next;

    assign d       = a_sh[0] ^ b_sh[0] ^ br;
    assign br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= bin;
                        res   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= br_next;
                    res  <= {d, res[WIDTH-1:1]};
                    cnt  <= cnt + CW'(1);
                    // ovf compares borrow into the MSB stage with borrow out of it
                    if (cnt == LAST) begin
                        diff  <= {d, res[WIDTH-1:1]};
                        bout  <= br_next;
                        ovf   <= br ^ br_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference model.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; returns {bout, ovf, diff}
    function automatic logic [9:0] ref_sub(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        int ua, ub, sa, sb, ci, ud, sd;
        logic [7:0] dv;
        ua = av; ub = bv; ci = bi;
        sa = $signed(av); sb = $signed(bv);
        ud = ua - ub - ci;
        sd = sa - sb - ci;
        dv = ud[7:0];
        return {(ua < ub + ci), (sd < -128 || sd > 127), dv};
    endfunction

    // Launch one operation, scramble inputs after accept, wait for done (bounded).
    // Returns at the negedge of the done cycle; done_cyc = -1 on timeout.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                          output int done_cyc, output int busy_cnt);
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        done_cyc = -1;
        busy_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff got %h exp 00", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout got %b exp 0", bout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_basic();
        int dc, bc;
        run_op(8'h5A, 8'h23, 1'b0, dc, bc);
        checks++; if (dc !== 9) begin errors++; $display("FAIL basic_done_cycle got %0d exp 9", dc); end
        checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 8", bc); end
        checks++; if (diff !== 8'h37) begin errors++; $display("FAIL basic_diff got %h exp 37", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL basic_bout got %b exp 0", bout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b exp 0", ovf); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", done); end
        checks++; if (diff !== 8'h37) begin errors++; $display("FAIL basic_hold got %h exp 37", diff); end
    endtask

    task automatic test_directed();
        logic [7:0] ta [4] = '{8'h00, 8'h7F, 8'h80, 8'h10};
        logic [7:0] tb [4] = '{8'h01, 8'hFF, 8'h01, 8'h0F};
        logic       tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] ed [4] = '{8'hFF, 8'h80, 8'h7F, 8'h00};
        logic       eb [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       eo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int dc, bc;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], tc[i], dc, bc);
            checks++; if (dc !== 9) begin errors++; $display("FAIL dir%0d_done_cycle got %0d exp 9", i, dc); end
            checks++; if (diff !== ed[i]) begin errors++; $display("FAIL dir%0d_diff got %h exp %h", i, diff, ed[i]); end
            checks++; if (bout !== eb[i]) begin errors++; $display("FAIL dir%0d_bout got %b exp %b", i, bout, eb[i]); end
            checks++; if (ovf !== eo[i]) begin errors++; $display("FAIL dir%0d_ovf got %b exp %b", i, ovf, eo[i]); end
        end
    endtask

    task automatic test_random();
        int dc, bc;
        logic [7:0] ra, rb;
        logic       rc;
        logic [9:0] exp;
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp = ref_sub(ra, rb, rc);
            run_op(ra, rb, rc, dc, bc);
            checks++; if (dc !== 9) begin errors++; $display("FAIL rand%0d_done_cycle got %0d exp 9", i, dc); end
            checks++; if ({bout, ovf, diff} !== exp)
                begin errors++; $display("FAIL rand%0d %h-%h-%b got bout=%b ovf=%b diff=%h exp bout=%b ovf=%b diff=%h",
                    i, ra, rb, rc, bout, ovf, diff, exp[9], exp[8], exp[7:0]); end
        end
    endtask

    task automatic test_start_during_shift();
        int npulse = 0;
        logic [7:0] first_diff = 8'h00;
        @(negedge clk);
        a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (done) begin
                if (npulse == 0) first_diff = diff;
                npulse++;
            end
            start = (c == 4);
            if (c == 4) begin a = 8'hFF; b = 8'h00; end
            @(negedge clk);
        end
        checks++; if (npulse !== 1) begin errors++; $display("FAIL sds_pulses got %0d exp 1", npulse); end
        checks++; if (first_diff !== 8'h37) begin errors++; $display("FAIL sds_diff got %h exp 37", first_diff); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sds_idle_busy got %b exp 0", busy); end
        checks++; if (diff !== 8'h37) begin errors++; $display("FAIL sds_hold got %h exp 37", diff); end
    endtask

    task automatic test_back_to_back();
        int dc, bc;
        int holdbad = 0;
        int dc2 = -1;
        run_op(8'h5A, 8'h23, 1'b0, dc, bc);
        a = 8'h03; b = 8'h05; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_rise got %b exp 1", busy); end
        for (int c = 1; c <= 20; c++) begin
            if (done) begin
                dc2 = c;
                break;
            end
            if (diff !== 8'h37) holdbad++;
            @(negedge clk);
        end
        checks++; if (dc !== 9) begin errors++; $display("FAIL b2b_first_done got %0d exp 9", dc); end
        checks++; if (dc2 !== 9) begin errors++; $display("FAIL b2b_second_spacing got %0d exp 9", dc2); end
        checks++; if (holdbad !== 0) begin errors++; $display("FAIL b2b_first_hold got %0d bad cycles exp 0", holdbad); end
        checks++; if (diff !== 8'hFE) begin errors++; $display("FAIL b2b_diff got %h exp fe", diff); end
        checks++; if (bout !== 1'b1) begin errors++; $display("FAIL b2b_bout got %b exp 1", bout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_reset_mid();
        int dc, bc;
        int spurious = 0;
        @(negedge clk);
        a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, bout, ovf, diff} !== 12'h000)
            begin errors++; $display("FAIL rstmid_async got busy=%b done=%b bout=%b ovf=%b diff=%h exp all 0",
                busy, done, bout, ovf, diff); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (done || busy) spurious++;
            @(negedge clk);
        end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d active cycles exp 0", spurious); end
        run_op(8'h5A, 8'h23, 1'b0, dc, bc);
        checks++; if (dc !== 9) begin errors++; $display("FAIL rstmid_redo_done got %0d exp 9", dc); end
        checks++; if (diff !== 8'h37) begin errors++; $display("FAIL rstmid_redo_diff got %h exp 37", diff); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_random();
        test_start_during_shift();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
